hex_scan_ctrl: RTL and testbench
================================

HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

Interface
REQ-001 Parameter SLOT_CYCLES, default 4: clock cycles a digit is driven per scan slot (>=1).
REQ-002 Parameter DEAD_CYCLES, default 1: clock cycles with all anodes off before each slot (>=1).
REQ-003 Port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 Port resetn  input  1  reset, asynchronous and active-low.
REQ-005 Port enable  input  1  1 = scan display; 0 = display dark.
REQ-006 Port wr_valid  input  1  write request.
REQ-007 Port wr_ready  output  1  write buffer free; a write is accepted on a cycle with wr_valid=1 and wr_ready=1.
REQ-008 Port wr_addr  input  2  target digit index 0..3.
REQ-009 Port wr_data  input  4  hex value for the target digit.
REQ-010 Port wr_blank  input  1  1 = target digit shown blank (seg=7'h7F) regardless of value.
REQ-011 Port digit_an  output  4  digit anode selects, active-low, one-hot-low or all high.
REQ-012 Port seg  output  7  segment pattern, active-low, bit0=a .. bit6=g.
REQ-013 Port frame_done  output  1  one-cycle pulse when digit 3's slot completes.

Function
REQ-014 The block SHALL hold four digit registers (4-bit value plus blank flag) and one single-entry write buffer.
REQ-015 FSM states SHALL be IDLE, DEAD, ON; a 2-bit index idx selects the current digit.
REQ-016 IDLE: digit_an=4'hF, seg=7'h7F; move to DEAD the cycle after enable=1 is sampled.
REQ-017 DEAD: digit_an=4'hF, seg=7'h7F for exactly DEAD_CYCLES cycles, then ON.
REQ-018 ON: digit_an bit idx low, others high; seg = decode of digit idx (7'h7F if blank) for exactly SLOT_CYCLES cycles, then DEAD with idx+1 modulo 4.
REQ-019 On the ON->DEAD transition with idx=3, frame_done SHALL be 1 for that single cycle after the edge (first DEAD cycle); idx wraps to 0.
REQ-020 enable=0 sampled in any state SHALL force IDLE and idx=0 on the next edge; a partial slot is abandoned without frame_done.
REQ-021 Decode (hex, active-low) SHALL be: 0 40, 1 79, 2 24, 3 30, 4 19, 5 12, 6 02, 7 78, 8 00, 9 10, A 08, b 03, C 46, d 21, E 06, F 0E.
REQ-022 Outputs SHALL be a Moore function of state, idx and digit registers; no combinational path from any input to digit_an, seg or frame_done.
REQ-023 An accepted write SHALL load the buffer and drive wr_ready=0 from the next cycle.
REQ-024 A buffered write SHALL commit to its digit register on the first cycle the FSM is in DEAD or IDLE; the buffer empties and wr_ready=1 the following cycle.
REQ-025 Digit registers SHALL never change while in ON, so a lit digit never changes mid-slot.
REQ-026 wr_valid while wr_ready=0 SHALL be ignored and not stored; the requester holds it.
REQ-027 Commit and enable falling on the same cycle: both take effect; commit is not lost.
REQ-028 Writes to the digit currently lit SHALL become visible on that digit's next slot.

Reset
REQ-029 resetn=0 SHALL immediately force: state IDLE, idx 0, all digit values 0, all blank flags 1, buffer empty, wr_ready 1, digit_an 4'hF, seg 7'h7F, frame_done 0.
REQ-030 Reset asserted mid-slot or with a buffered write SHALL discard the slot and the write.
REQ-031 After resetn rises, the first edge with enable=1 starts the DEAD->ON sequence at idx 0.

Verification
REQ-032 Reset, enable=1, defaults: digit_an cycles F,E,E,E,E,F,D,D,D,D,F,B.. (period 20); seg stays 7F (all blank); frame_done every 20 cycles.
REQ-033 Write digits 0..3 = 1,A,b,F unblanked, then scan: seg during slots = 79, 08, 03, 0E with digit_an E,D,B,7 respectively.
REQ-034 Write to digit 2 issued during digit 2's ON slot: seg for that slot unchanged; wr_ready low until next DEAD commit; new value on the following frame.
REQ-035 Back-to-back wr_valid for two cycles during ON: first accepted, second ignored (wr_ready=0) until commit; held request accepted after.
REQ-036 Drop enable in mid-ON of idx 2: next cycle digit_an=F, seg=7F, no frame_done; re-enable restarts at idx 0 after DEAD.
REQ-037 Assert resetn=0 mid-slot with buffered write: outputs go dark without waiting for a clock edge; wr_ready=1; written digit stays blank.

Source files
------------

// File: rtl/hex_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with blanking dead time between
// slots and a single-entry write buffer that only commits while no digit is lit.
module hex_scan_ctrl #(
   parameter int SLOT_CYCLES = 4,
   parameter int DEAD_CYCLES = 1
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       enable,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic [1:0] wr_addr,
   input  logic [3:0] wr_data,
   input  logic       wr_blank,
   output logic [3:0] digit_an,
   output logic [6:0] seg,
   output logic       frame_done,
   output logic [1:0] dbg_state_o,
   output logic [1:0] dbg_idx_o
);

   localparam int CNT_MAX = (SLOT_CYCLES > DEAD_CYCLES) ? SLOT_CYCLES : DEAD_CYCLES;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
   localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DEAD = 2'd1,
      S_ON   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            frame_q, frame_d;

   logic [3:0][3:0] val_q;
   logic [3:0]      blank_q;

   logic            buf_full_q;
   logic [1:0]      buf_addr_q;
   logic [3:0]      buf_data_q;
   logic            buf_blank_q;

   logic            accept;
   logic            commit;

   // Write handshake: a transfer happens on any cycle with wr_valid=1 and
   // wr_ready=1; the requester keeps wr_valid and its payload stable until then.
   assign wr_ready = ~buf_full_q;
   assign accept   = wr_valid & ~buf_full_q;
   assign commit   = buf_full_q & (state_q != S_ON);

   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] p;
      case (v)
         4'h0: p = 7'h40;
         4'h1: p = 7'h79;
         4'h2: p = 7'h24;
         4'h3: p = 7'h30;
         4'h4: p = 7'h19;
         4'h5: p = 7'h12;
         4'h6: p = 7'h02;
         4'h7: p = 7'h78;
         4'h8: p = 7'h00;
         4'h9: p = 7'h10;
         4'hA: p = 7'h08;
         4'hB: p = 7'h03;
         4'hC: p = 7'h46;
         4'hD: p = 7'h21;
         4'hE: p = 7'h06;
         default: p = 7'h0E;
      endcase
      return p;
   endfunction

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         idx_q   <= 2'd0;
         cnt_q   <= '0;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         frame_q <= frame_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      frame_d = 1'b0;
      if (!enable) begin
         state_d = S_IDLE;
         idx_d   = 2'd0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_DEAD;
               cnt_d   = '0;
            end
            S_DEAD: begin
               if (cnt_q == DEAD_LAST) begin
                  state_d = S_ON;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_ON: begin
               if (cnt_q == SLOT_LAST) begin
                  state_d = S_DEAD;
                  cnt_d   = '0;
                  idx_d   = idx_q + 2'd1;
                  frame_d = (idx_q == 2'd3);
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
               idx_d   = 2'd0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Accept needs an empty buffer and commit a full one, so they never coincide.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         val_q       <= '0;
         blank_q     <= 4'hF;
         buf_full_q  <= 1'b0;
         buf_addr_q  <= 2'd0;
         buf_data_q  <= 4'd0;
         buf_blank_q <= 1'b0;
      end else begin
         if (commit) begin
            val_q[buf_addr_q]   <= buf_data_q;
            blank_q[buf_addr_q] <= buf_blank_q;
            buf_full_q          <= 1'b0;
         end
         if (accept) begin
            buf_full_q  <= 1'b1;
            buf_addr_q  <= wr_addr;
            buf_data_q  <= wr_data;
            buf_blank_q <= wr_blank;
         end
      end
   end

   always_comb begin
      digit_an = 4'hF;
      seg      = 7'h7F;
      if (state_q == S_ON) begin
         digit_an = ~(4'b0001 << idx_q);
         seg      = blank_q[idx_q] ? 7'h7F : decode(val_q[idx_q]);
      end
   end

   assign frame_done  = frame_q;
   assign dbg_state_o = state_q;
   assign dbg_idx_o   = idx_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Bench for hex_scan_ctrl: a frame-position model predicts anodes, segments,
// frame pulses and write readiness every cycle under directed and random traffic.
module tb_hex_scan_ctrl;

   localparam int D  = 1;
   localparam int S  = 4;
   localparam int P  = D + S;
   localparam int FR = 4 * P;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       enable = 1'b0;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [1:0] wr_addr = 2'd0;
   logic [3:0] wr_data = 4'd0;
   logic       wr_blank = 1'b0;
   logic [3:0] digit_an;
   logic [6:0] seg;
   logic       frame_done;
   logic [1:0] dbg_state;
   logic [1:0] dbg_idx;

   hex_scan_ctrl #(.SLOT_CYCLES(S), .DEAD_CYCLES(D)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .enable      (enable),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_blank    (wr_blank),
      .digit_an    (digit_an),
      .seg         (seg),
      .frame_done  (frame_done),
      .dbg_state_o (dbg_state),
      .dbg_idx_o   (dbg_idx)
   );

   always #5 clock = ~clock;

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   int errors = 0;
   int checks = 0;
   int fd_cnt = 0;

   logic [6:0] dec_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Model: m_run says a scan is in progress, m_t is the cycle position in the
   // 4-slot frame (each slot = D dark cycles followed by S lit cycles).
   bit         m_run;
   int         m_t;
   logic [3:0] m_val [4];
   bit         m_blank [4];
   bit         m_buf_full;
   int         m_buf_addr;
   logic [3:0] m_buf_data;
   bit         m_buf_blank;
   bit         m_frame;
   bit         last_acc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_lit();
      return m_run && ((m_t % P) >= D);
   endfunction

   function automatic logic [3:0] exp_an();
      if (!m_lit()) return 4'hF;
      return ~(4'b0001 << (m_t / P));
   endfunction

   function automatic logic [6:0] exp_seg();
      int i;
      if (!m_lit()) return 7'h7F;
      i = m_t / P;
      return m_blank[i] ? 7'h7F : dec_tbl[m_val[i]];
   endfunction

   task automatic model_reset();
      m_run = 0;
      m_t = 0;
      for (int i = 0; i < 4; i++) begin
         m_val[i] = 4'd0;
         m_blank[i] = 1;
      end
      m_buf_full = 0;
      m_frame = 0;
      last_acc = 0;
   endtask

   task automatic check_outputs();
      check("digit_an", digit_an, exp_an());
      check("seg", seg, exp_seg());
      check("frame_done", frame_done, m_frame);
      check("wr_ready", wr_ready, !m_buf_full);
   endtask

   task automatic step();
      bit acc;
      bit com;
      acc = wr_valid && !m_buf_full;
      com = m_buf_full && !m_lit();
      @(posedge clock);
      #1;
      m_frame = enable && m_run && (m_t == FR - 1);
      if (!enable) begin
         m_run = 0;
         m_t = 0;
      end else if (!m_run) begin
         m_run = 1;
         m_t = 0;
      end else begin
         m_t = (m_t + 1) % FR;
      end
      if (com) begin
         m_val[m_buf_addr] = m_buf_data;
         m_blank[m_buf_addr] = m_buf_blank;
         m_buf_full = 0;
      end
      if (acc) begin
         m_buf_full = 1;
         m_buf_addr = int'(wr_addr);
         m_buf_data = wr_data;
         m_buf_blank = wr_blank;
      end
      last_acc = acc;
      if (frame_done) fd_cnt++;
      check_outputs();
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic do_write(input logic [1:0] a, input logic [3:0] d, input logic b);
      int k;
      wr_valid = 1'b1;
      wr_addr = a;
      wr_data = d;
      wr_blank = b;
      k = 0;
      do begin
         step();
         k++;
      end while (!last_acc && k < 200);
      check("wr_accept", last_acc, 1);
      wr_valid = 1'b0;
   endtask

   // Returns just after the edge that starts the first lit cycle of digit i.
   task automatic wait_on_idx(input int i);
      int k;
      k = 0;
      do begin
         step();
         k++;
      end while (!(m_run && (m_t == i * P + D)) && k < 200);
      check("wait_slot", (m_run && (m_t == i * P + D)), 1);
   endtask

   initial begin
      model_reset();
      #1;
      check("rst_an", digit_an, 4'hF);
      check("rst_seg", seg, 7'h7F);
      check("rst_frame", frame_done, 1'b0);
      check("rst_ready", wr_ready, 1'b1);
      repeat (2) @(posedge clock);
      #1;
      resetn = 1'b1;
      check_outputs();

      // all-blank scan: anode sequence and one frame pulse per 20 cycles
      enable = 1'b1;
      fd_cnt = 0;
      step();
      check("first_dead_an", digit_an, 4'hF);
      step();
      check("first_on_an", digit_an, 4'hE);
      run(43);
      check("frame_count", fd_cnt, 2);

      do_write(2'd0, 4'h1, 1'b0);
      do_write(2'd1, 4'hA, 1'b0);
      do_write(2'd2, 4'hB, 1'b0);
      do_write(2'd3, 4'hF, 1'b0);
      run(25);
      wait_on_idx(0);
      check("d0_seg", seg, 7'h79);
      check("d0_an", digit_an, 4'hE);
      wait_on_idx(1);
      check("d1_seg", seg, 7'h08);
      check("d1_an", digit_an, 4'hD);
      wait_on_idx(2);
      check("d2_seg", seg, 7'h03);
      check("d2_an", digit_an, 4'hB);
      wait_on_idx(3);
      check("d3_seg", seg, 7'h0E);
      check("d3_an", digit_an, 4'h7);

      // write to the lit digit: held off until the following dark cycle
      wait_on_idx(2);
      do_write(2'd2, 4'h5, 1'b0);
      check("lit_wr_ready", wr_ready, 1'b0);
      while (m_lit()) begin
         check("lit_seg_hold", seg, 7'h03);
         step();
      end
      step();
      check("commit_ready", wr_ready, 1'b1);
      wait_on_idx(2);
      check("d2_new_seg", seg, 7'h12);

      // back-to-back requests during a lit slot
      wait_on_idx(1);
      wr_valid = 1'b1;
      wr_addr = 2'd0;
      wr_data = 4'h7;
      wr_blank = 1'b0;
      step();
      check("b2b_first_acc", last_acc, 1);
      wr_addr = 2'd3;
      wr_data = 4'h8;
      step();
      check("b2b_second_ign", last_acc, 0);
      do_write(2'd3, 4'h8, 1'b0);
      wait_on_idx(3);
      check("held_wr_seg", seg, 7'h00);
      wait_on_idx(0);
      check("first_wr_seg", seg, 7'h78);

      // drop enable in the middle of digit 2's slot
      wait_on_idx(2);
      step();
      enable = 1'b0;
      fd_cnt = 0;
      step();
      check("dis_an", digit_an, 4'hF);
      check("dis_seg", seg, 7'h7F);
      check("dis_frame", frame_done, 1'b0);
      run(3);
      enable = 1'b1;
      step();
      check("reen_dead_an", digit_an, 4'hF);
      step();
      check("reen_idx0_an", digit_an, 4'hE);
      check("no_partial_frame", fd_cnt, 0);

      // asynchronous reset with a buffered write pending
      wait_on_idx(1);
      do_write(2'd1, 4'h3, 1'b0);
      check("buffered", wr_ready, 1'b0);
      #2;
      resetn = 1'b0;
      #1;
      check("arst_an", digit_an, 4'hF);
      check("arst_seg", seg, 7'h7F);
      check("arst_ready", wr_ready, 1'b1);
      check("arst_frame", frame_done, 1'b0);
      @(posedge clock);
      #1;
      resetn = 1'b1;
      model_reset();
      run(5);
      wait_on_idx(1);
      check("rst_wr_blank", seg, 7'h7F);

      // random traffic against the model
      for (int c = 0; c < 800; c++) begin
         enable = ($urandom_range(0, 24) != 0);
         if (wr_valid && last_acc) wr_valid = 1'b0;
         if (!wr_valid && ($urandom_range(0, 3) == 0)) begin
            wr_valid = 1'b1;
            wr_addr = 2'($urandom_range(0, 3));
            wr_data = 4'($urandom_range(0, 15));
            wr_blank = ($urandom_range(0, 4) == 0);
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
